// File: rtl/video_dma_pkg.sv
// Shared definitions for the video DMA engines (capture writer and frame reader).
package video_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_BURST     = 2'd2
    } dma_state_e;

    localparam int unsigned DEFAULT_H_RES     = 32'd1280;
    localparam int unsigned DEFAULT_V_RES     = 32'd720;
    localparam int unsigned DEFAULT_BURST_LEN = 32'd64;
    localparam int unsigned BYTES_PER_WORD    = 32'd4;

    // Byte distance covered by one burst of burst_len 32-bit words.
    function automatic logic [31:0] burst_addr_step(input int unsigned burst_len);
        return 32'(burst_len * BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/video_dma_writer_if.sv
// Avalon-MM burst write bus plus the show-ahead capture FIFO read port.
interface video_dma_writer_if;

    logic        m_waitrequest;
    logic [31:0] m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [7:0]  m_burstcount;
    logic [3:0]  m_byteenable;
    logic [9:0]  fifo_used;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_en;

    modport master (
        input  m_waitrequest,
        output m_address,
        output m_write,
        output m_writedata,
        output m_burstcount,
        output m_byteenable,
        input  fifo_used,
        input  fifo_rd_data,
        output fifo_rd_en
    );

    modport slave (
        output m_waitrequest,
        input  m_address,
        input  m_write,
        input  m_writedata,
        input  m_burstcount,
        input  m_byteenable,
        output fifo_used,
        output fifo_rd_data,
        input  fifo_rd_en
    );

endinterface

// File: rtl/video_dma_writer.sv
// Capture-side frame DMA: drains the capture FIFO into a linear frame buffer
// using fixed-length Avalon-MM write bursts, single-shot or vsync-triggered.
module video_dma_writer
    import video_dma_pkg::*;
#(
    parameter int unsigned BURST_LEN        = DEFAULT_BURST_LEN,
    parameter int unsigned FIFO_DEPTH       = 32'd512,
    parameter int unsigned H_RES            = DEFAULT_H_RES,
    parameter int unsigned V_RES            = DEFAULT_V_RES,
    parameter int unsigned FRAME_SIZE_WORDS = H_RES * V_RES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        start_addr,
    input  logic               dma_start,
    input  logic               dma_cont_en,
    input  logic               vsync_edge,
    output logic               dma_done,
    output logic               busy,
    video_dma_writer_if.master bus
);

    localparam logic [31:0] BURST_LEN_W = 32'(BURST_LEN);
    localparam logic [31:0] FRAME_W     = 32'(FRAME_SIZE_WORDS);
    localparam logic [31:0] ADDR_STEP   = burst_addr_step(BURST_LEN);

    generate
        if (((FRAME_SIZE_WORDS % BURST_LEN) != 0) || (BURST_LEN < 1) ||
            (BURST_LEN > 255) || (BURST_LEN > FIFO_DEPTH)) begin : g_param_check
            $error("video_dma_writer: frame size must be a multiple of a burst of 1..255 words that fits the FIFO");
        end
    endgenerate

    dma_state_e  state_q,       state_d;
    logic [31:0] addr_reg_q,    addr_reg_d;
    logic [31:0] words_q,       words_d;
    logic [31:0] beat_cnt_q,    beat_cnt_d;
    logic        cont_mode_q,   cont_mode_d;
    logic [31:0] m_address_q,   m_address_d;
    logic        m_write_q,     m_write_d;
    logic        dma_done_q,    dma_done_d;
    logic        busy_q,        busy_d;
    logic        beat_accept_s;
    logic        fifo_ready_s;

    assign beat_accept_s     = m_write_q && !bus.m_waitrequest;
    assign fifo_ready_s      = ({22'd0, bus.fifo_used} >= BURST_LEN_W);

    assign bus.m_address     = m_address_q;
    assign bus.m_write       = m_write_q;
    assign bus.m_writedata   = bus.fifo_rd_data;
    assign bus.m_burstcount  = BURST_LEN_W[7:0];
    assign bus.m_byteenable  = 4'hF;
    assign bus.fifo_rd_en    = beat_accept_s;
    assign dma_done          = dma_done_q;
    assign busy              = busy_q;

    // Next-state and next-output computation for the frame/burst sequencer.
    always_comb begin
        state_d     = state_q;
        addr_reg_d  = addr_reg_q;
        words_d     = words_q;
        beat_cnt_d  = beat_cnt_q;
        cont_mode_d = cont_mode_q;
        m_address_d = m_address_q;
        m_write_d   = m_write_q;
        dma_done_d  = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (dma_start) begin
                    addr_reg_d  = start_addr;
                    words_d     = 32'd0;
                    cont_mode_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_WAIT_DATA;
                end else if (dma_cont_en && vsync_edge) begin
                    addr_reg_d  = start_addr;
                    words_d     = 32'd0;
                    cont_mode_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_WAIT_DATA;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_WAIT_DATA: begin
                // Launch only a fully buffered burst so beats never starve mid-burst.
                if (fifo_ready_s) begin
                    m_address_d = addr_reg_q;
                    beat_cnt_d  = 32'd0;
                    m_write_d   = 1'b1;
                    state_d     = ST_BURST;
                end else begin
                    state_d     = ST_WAIT_DATA;
                end
            end

            ST_BURST: begin
                if (beat_accept_s) begin
                    if (beat_cnt_q == (BURST_LEN_W - 32'd1)) begin
                        m_write_d  = 1'b0;
                        addr_reg_d = addr_reg_q + ADDR_STEP;
                        words_d    = words_q + BURST_LEN_W;
                        if (words_d == FRAME_W) begin
                            dma_done_d = 1'b1;
                            busy_d     = 1'b0;
                            state_d    = ST_IDLE;
                        end else begin
                            state_d    = ST_WAIT_DATA;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 32'd1;
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end

            default: begin
                m_write_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_reg_q  <= 32'd0;
            words_q     <= 32'd0;
            beat_cnt_q  <= 32'd0;
            cont_mode_q <= 1'b0;
            m_address_q <= 32'd0;
            m_write_q   <= 1'b0;
            dma_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_reg_q  <= addr_reg_d;
            words_q     <= words_d;
            beat_cnt_q  <= beat_cnt_d;
            cont_mode_q <= cont_mode_d;
            m_address_q <= m_address_d;
            m_write_q   <= m_write_d;
            dma_done_q  <= dma_done_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_video_dma_writer.sv
// Scoreboard bench for video_dma_writer: a FIFO/slave model drives the bus, a
// negedge monitor checks every accepted beat against queued expectations.
module tb_video_dma_writer;
    import video_dma_pkg::*;

    localparam int unsigned TB_BL    = 8;
    localparam int unsigned TB_FRAME = 128;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] start_addr;
    logic        dma_start;
    logic        dma_cont_en;
    logic        vsync_edge;
    logic        dma_done;
    logic        busy;

    video_dma_writer_if bus ();

    video_dma_writer #(
        .BURST_LEN       (TB_BL),
        .FIFO_DEPTH      (512),
        .H_RES           (16),
        .V_RES           (8),
        .FRAME_SIZE_WORDS(TB_FRAME)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_addr (start_addr),
        .dma_start  (dma_start),
        .dma_cont_en(dma_cont_en),
        .vsync_edge (vsync_edge),
        .dma_done   (dma_done),
        .busy       (busy),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    beat_t       exp_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          rd_en_cnt = 0;
    bit          pop_req = 1'b0;
    bit          rand_wr = 1'b0;
    bit          trickle_en = 1'b0;
    int          trickle_left = 0;
    int          tick = 0;
    logic [31:0] trickle_data = 32'd0;
    bit          in_burst = 1'b0;
    logic [31:0] burst_addr = 32'd0;
    int          beat_idx = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endfunction

    // FIFO and slave model: pops accepted beats, trickle-feeds, drives waitrequest.
    initial begin
        bus.m_waitrequest = 1'b0;
        bus.fifo_used     = 10'd0;
        bus.fifo_rd_data  = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (pop_req) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                pop_req = 1'b0;
            end
            if (trickle_en && trickle_left > 0) begin
                tick++;
                if (tick >= 3) begin
                    fifo_q.push_back(trickle_data);
                    trickle_data = trickle_data + 32'd1;
                    trickle_left--;
                    tick = 0;
                end
            end
            bus.fifo_used    = 10'(fifo_q.size());
            bus.fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
            bus.m_waitrequest = rand_wr ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: compares each accepted beat with the scoreboard and checks bus rules.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("rd_en_is_accept", 32'(bus.fifo_rd_en), 32'(bus.m_write && !bus.m_waitrequest));
                if (bus.fifo_rd_en) rd_en_cnt++;
                if (bus.m_write) begin
                    check("write_with_empty_fifo", 32'(bus.fifo_used == 10'd0), 32'd0);
                    if (!in_burst) begin
                        in_burst   = 1'b1;
                        burst_addr = bus.m_address;
                        beat_idx   = 0;
                        check("launch_fill", 32'(bus.fifo_used >= 10'd8), 32'd1);
                        check("burstcount", 32'(bus.m_burstcount), 32'd8);
                        check("byteenable", 32'(bus.m_byteenable), 32'hF);
                    end else begin
                        check("addr_stable", bus.m_address, burst_addr);
                        check("burstcount_stable", 32'(bus.m_burstcount), 32'd8);
                    end
                    if (!bus.m_waitrequest) begin
                        pop_req = 1'b1;
                        if (exp_q.size() == 0) begin
                            check("unexpected_beat", 32'd1, 32'd0);
                        end else begin
                            beat_t e;
                            e = exp_q.pop_front();
                            check("beat_addr", burst_addr + 32'(beat_idx * 4), e.addr);
                            check("beat_data", bus.m_writedata, e.data);
                            mem[burst_addr + 32'(beat_idx * 4)] = bus.m_writedata;
                        end
                        beat_idx++;
                    end
                end else if (in_burst) begin
                    check("beats_per_burst", 32'(beat_idx), 32'd8);
                    in_burst = 1'b0;
                end
                if (dma_done) begin
                    done_cnt++;
                    check("busy_low_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [31:0] addr, input logic [31:0] d0, input bit prefill);
        for (int i = 0; i < TB_FRAME; i++) begin
            beat_t b;
            b.addr = addr + 32'(i * 4);
            b.data = d0 + 32'(i);
            exp_q.push_back(b);
            if (prefill) fifo_q.push_back(d0 + 32'(i));
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        dma_start = 1'b1;
        @(posedge clk); #1;
        dma_start = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(posedge clk); #1;
        vsync_edge = 1'b1;
        @(posedge clk); #1;
        vsync_edge = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (done_cnt < target) check({name, "_timeout"}, 32'(done_cnt), 32'(target));
        cycles(2);
    endtask

    initial begin
        int target;
        reset_n = 1'b0; start_addr = 32'h1000_0000;
        dma_start = 1'b0; dma_cont_en = 1'b0; vsync_edge = 1'b0;
        cycles(3);
        @(negedge clk);
        check("rst_m_write", 32'(bus.m_write), 32'd0);
        check("rst_m_address", bus.m_address, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(dma_done), 32'd0);
        cycles(1);
        reset_n = 1'b1;
        cycles(2);

        // Single frame, prefilled, no stalls; start_addr changed after launch.
        target = 1; rd_en_cnt = 0;
        expect_frame(32'h1000_0000, 32'd0, 1'b1);
        cycles(1);
        pulse_start();
        start_addr = 32'h5555_0000;
        wait_done(target, 1000, "frame1");
        check("frame1_busy", 32'(busy), 32'd0);
        check("frame1_pops", 32'(rd_en_cnt), 32'd128);
        check("frame1_exp_left", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < TB_FRAME; i++) begin
            logic [31:0] a;
            a = 32'h1000_0000 + 32'(i * 4);
            check("mem", mem.exists(a) ? mem[a] : 32'hDEAD_BEEF, 32'(i));
        end
        mem.delete();

        // Random waitrequest.
        target = 2; rd_en_cnt = 0; rand_wr = 1'b1; start_addr = 32'h1000_0000;
        expect_frame(32'h1000_0000, 32'd200, 1'b1);
        cycles(1);
        pulse_start();
        wait_done(target, 2000, "stall");
        rand_wr = 1'b0;
        check("stall_pops", 32'(rd_en_cnt), 32'd128);
        check("stall_exp_left", 32'(exp_q.size()), 32'd0);

        // Trickle-fed FIFO, one word every third cycle.
        target = 3; rd_en_cnt = 0;
        expect_frame(32'h1000_0000, 32'd500, 1'b0);
        trickle_data = 32'd500; trickle_left = TB_FRAME; tick = 0; trickle_en = 1'b1;
        pulse_start();
        wait_done(target, 3000, "trickle");
        trickle_en = 1'b0;
        check("trickle_pops", 32'(rd_en_cnt), 32'd128);
        check("trickle_busy", 32'(busy), 32'd0);

        // Continuous mode: three vsync frames, extra vsyncs while busy and after disable.
        dma_cont_en = 1'b1; start_addr = 32'h2000_0000;
        expect_frame(32'h2000_0000, 32'd1000, 1'b1);
        cycles(1);
        pulse_vsync();
        cycles(5);
        check("cont1_busy", 32'(busy), 32'd1);
        pulse_vsync();
        target = 4;
        wait_done(target, 1000, "cont1");
        start_addr = 32'h2000_1000;
        expect_frame(32'h2000_1000, 32'd2000, 1'b1);
        cycles(1);
        pulse_vsync();
        target = 5;
        wait_done(target, 1000, "cont2");
        start_addr = 32'h2000_2000;
        expect_frame(32'h2000_2000, 32'd3000, 1'b1);
        cycles(1);
        pulse_vsync();
        cycles(20);
        dma_cont_en = 1'b0;
        target = 6;
        wait_done(target, 1000, "cont3");
        pulse_vsync();
        cycles(40);
        check("no_4th_frame_busy", 32'(busy), 32'd0);
        check("no_4th_frame_done", 32'(done_cnt), 32'd6);
        check("cont_exp_left", 32'(exp_q.size()), 32'd0);

        // Simultaneous dma_start and vsync with continuous enabled: single-shot wins.
        dma_cont_en = 1'b1; start_addr = 32'h3000_0000;
        expect_frame(32'h3000_0000, 32'd4000, 1'b1);
        cycles(1);
        @(posedge clk); #1;
        dma_start = 1'b1; vsync_edge = 1'b1;
        @(posedge clk); #1;
        dma_start = 1'b0; vsync_edge = 1'b0;
        check("both_cont_mode", 32'(dut.cont_mode_q), 32'd0);
        target = 7;
        wait_done(target, 1000, "both");
        dma_cont_en = 1'b0;
        cycles(30);
        check("both_no_restart", 32'(busy), 32'd0);

        // Reset in the middle of a burst, then a clean frame.
        start_addr = 32'h1000_0000;
        expect_frame(32'h1000_0000, 32'd7000, 1'b1);
        cycles(1);
        pulse_start();
        cycles(5);
        check("pre_reset_write", 32'(bus.m_write), 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        in_burst = 1'b0; pop_req = 1'b0;
        exp_q.delete(); fifo_q.delete();
        @(negedge clk);
        check("rst_mid_m_write", 32'(bus.m_write), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_state", 32'(dut.state_q), 32'(ST_IDLE));
        cycles(2);
        rd_en_cnt = 0;
        expect_frame(32'h1000_0000, 32'd9000, 1'b1);
        cycles(1);
        pulse_start();
        target = 8;
        wait_done(target, 1000, "after_reset");
        check("after_reset_pops", 32'(rd_en_cnt), 32'd128);
        check("after_reset_exp_left", 32'(exp_q.size()), 32'd0);
        check("after_reset_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
